// File: rtl/sb_rx_fsm_if.sv
// Sideband RX FSM bus: deserializer/decoder strobes in, pattern/message events out.
interface sb_rx_fsm_if;
  logic        i_de_ser_done;
  logic [63:0] i_deser_data;
  logic        i_state;
  logic        i_header_valid;
  logic        i_rdi_valid;
  logic        i_data_valid;

  logic        o_rx_sb_start_pattern;
  logic        o_rx_sb_pattern_samp_done;
  logic        o_header_enable;
  logic        o_rdi_enable;
  logic        o_data_enable;
  logic        o_msg_valid;
  logic        o_rdi_msg;
  logic        o_rx_rsp_delivered;
  logic        o_parity_error;
  logic        o_adapter_enable;

  // Stimulus / upstream side: drives the strobes, observes the events.
  modport master (
    output i_de_ser_done, i_deser_data, i_state,
           i_header_valid, i_rdi_valid, i_data_valid,
    input  o_rx_sb_start_pattern, o_rx_sb_pattern_samp_done,
           o_header_enable, o_rdi_enable, o_data_enable,
           o_msg_valid, o_rdi_msg, o_rx_rsp_delivered,
           o_parity_error, o_adapter_enable
  );

  // FSM side.
  modport slave (
    input  i_de_ser_done, i_deser_data, i_state,
           i_header_valid, i_rdi_valid, i_data_valid,
    output o_rx_sb_start_pattern, o_rx_sb_pattern_samp_done,
           o_header_enable, o_rdi_enable, o_data_enable,
           o_msg_valid, o_rdi_msg, o_rx_rsp_delivered,
           o_parity_error, o_adapter_enable
  );
endinterface

// File: rtl/sb_rx_fsm.sv
// Sideband receive FSM: locks onto the 0xAAAA.. pattern pair, then classifies
// each deserialized header (adapter / RDI / PHY message, with parity checks)
// and sequences the header, data and RDI decoders.
module sb_rx_fsm (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sb_rx_fsm_if.slave     sb
);

  localparam logic [63:0] PATTERN    = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [4:0]  OP_WITH_DATA = 5'b11011;
  localparam logic [3:0]  MSG_RSP_LO   = 4'hA;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PATTERN_DETECT = 3'd1,
    GENERAL_DECODE = 3'd2,
    HEADER_DECODE  = 3'd3,
    DATA_WAIT      = 3'd4,
    DATA_DECODE    = 3'd5,
    RDI_DECODE     = 3'd6
  } state_t;

  state_t      r_state, w_nxt_state;

  // Only the header fields needed after the header word has gone are kept.
  logic [4:0]  r_hdr_opcode, w_nxt_hdr_opcode;
  logic [3:0]  r_hdr_msg_lo, w_nxt_hdr_msg_lo;
  logic        r_hdr_dp,     w_nxt_hdr_dp;

  logic r_start_pattern, r_samp_done, r_msg_valid, r_rdi_msg;
  logic r_rsp_delivered, r_parity_error, r_adapter_enable;
  logic w_start_pattern, w_samp_done, w_msg_valid, w_rdi_msg;
  logic w_rsp_delivered, w_parity_error, w_adapter_enable;

  logic w_is_pattern, w_cp_ok, w_dp_ok;

  assign w_is_pattern = (sb.i_deser_data == PATTERN);
  assign w_cp_ok      = (sb.i_deser_data[62] == ^sb.i_deser_data[61:0]);
  assign w_dp_ok      = (r_hdr_dp == ^sb.i_deser_data);

  // State, latched header fields and pulse outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= IDLE;
      r_hdr_opcode     <= '0;
      r_hdr_msg_lo     <= '0;
      r_hdr_dp         <= 1'b0;
      r_start_pattern  <= 1'b0;
      r_samp_done      <= 1'b0;
      r_msg_valid      <= 1'b0;
      r_rdi_msg        <= 1'b0;
      r_rsp_delivered  <= 1'b0;
      r_parity_error   <= 1'b0;
      r_adapter_enable <= 1'b0;
    end else begin
      r_state          <= w_nxt_state;
      r_hdr_opcode     <= w_nxt_hdr_opcode;
      r_hdr_msg_lo     <= w_nxt_hdr_msg_lo;
      r_hdr_dp         <= w_nxt_hdr_dp;
      r_start_pattern  <= w_start_pattern;
      r_samp_done      <= w_samp_done;
      r_msg_valid      <= w_msg_valid;
      r_rdi_msg        <= w_rdi_msg;
      r_rsp_delivered  <= w_rsp_delivered;
      r_parity_error   <= w_parity_error;
      r_adapter_enable <= w_adapter_enable;
    end
  end

  // Next-state and pulse decode; strobes not consumed by the current state drop.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_hdr_opcode = r_hdr_opcode;
    w_nxt_hdr_msg_lo = r_hdr_msg_lo;
    w_nxt_hdr_dp     = r_hdr_dp;
    w_start_pattern  = 1'b0;
    w_samp_done      = 1'b0;
    w_msg_valid      = 1'b0;
    w_rdi_msg        = 1'b0;
    w_rsp_delivered  = 1'b0;
    w_parity_error   = 1'b0;
    w_adapter_enable = 1'b0;

    case (r_state)
      IDLE: begin
        if (sb.i_de_ser_done && w_is_pattern) begin
          w_nxt_state     = PATTERN_DETECT;
          w_start_pattern = 1'b1;
        end
      end
      PATTERN_DETECT: begin
        if (sb.i_de_ser_done) begin
          if (!w_is_pattern) begin
            w_nxt_state = IDLE;
          end else if (sb.i_state) begin
            w_nxt_state = GENERAL_DECODE;
            w_samp_done = 1'b1;
          end
        end
      end
      GENERAL_DECODE: begin
        // Trailing pattern words after lock are dropped before any header check.
        if (sb.i_de_ser_done && !w_is_pattern) begin
          if (!w_cp_ok) begin
            w_parity_error = 1'b1;
          end else if (!sb.i_deser_data[56]) begin
            w_adapter_enable = 1'b1;
          end else if (sb.i_deser_data[21:18] == 4'h0) begin
            w_nxt_state = RDI_DECODE;
          end else begin
            w_nxt_state      = HEADER_DECODE;
            w_nxt_hdr_opcode = sb.i_deser_data[4:0];
            w_nxt_hdr_msg_lo = sb.i_deser_data[17:14];
            w_nxt_hdr_dp     = sb.i_deser_data[63];
          end
        end
      end
      HEADER_DECODE: begin
        if (sb.i_header_valid) begin
          if (r_hdr_opcode == OP_WITH_DATA) begin
            w_nxt_state = DATA_WAIT;
          end else begin
            w_nxt_state     = GENERAL_DECODE;
            w_msg_valid     = 1'b1;
            w_rsp_delivered = (r_hdr_msg_lo == MSG_RSP_LO);
          end
        end
      end
      DATA_WAIT: begin
        if (sb.i_de_ser_done) begin
          if (w_dp_ok) begin
            w_nxt_state = DATA_DECODE;
          end else begin
            w_nxt_state    = GENERAL_DECODE;
            w_parity_error = 1'b1;
          end
        end
      end
      DATA_DECODE: begin
        if (sb.i_data_valid) begin
          w_nxt_state     = GENERAL_DECODE;
          w_msg_valid     = 1'b1;
          w_rsp_delivered = (r_hdr_msg_lo == MSG_RSP_LO);
        end
      end
      RDI_DECODE: begin
        if (sb.i_rdi_valid) begin
          w_nxt_state = GENERAL_DECODE;
          w_rdi_msg   = 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign sb.o_rx_sb_start_pattern     = r_start_pattern;
  assign sb.o_rx_sb_pattern_samp_done = r_samp_done;
  assign sb.o_msg_valid               = r_msg_valid;
  assign sb.o_rdi_msg                 = r_rdi_msg;
  assign sb.o_rx_rsp_delivered        = r_rsp_delivered;
  assign sb.o_parity_error            = r_parity_error;
  assign sb.o_adapter_enable          = r_adapter_enable;

  // Decoder enables follow the registered state directly.
  assign sb.o_header_enable = (r_state == HEADER_DECODE);
  assign sb.o_data_enable   = (r_state == DATA_DECODE);
  assign sb.o_rdi_enable    = (r_state == RDI_DECODE);

endmodule

// File: tb/tb_sb_rx_fsm.sv
// Bench for sb_rx_fsm: directed vector table, hand-written reset corner cases,
// then randomized traffic against a transaction-level reference model.
module tb_sb_rx_fsm;

  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  sb_rx_fsm_if bus();

  sb_rx_fsm dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .sb      (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Output bundle: {start, samp, hen, ren, den, msg, rdi, rsp, perr, aen}
  function automatic logic [9:0] outs();
    return {bus.o_rx_sb_start_pattern, bus.o_rx_sb_pattern_samp_done,
            bus.o_header_enable, bus.o_rdi_enable, bus.o_data_enable,
            bus.o_msg_valid, bus.o_rdi_msg, bus.o_rx_rsp_delivered,
            bus.o_parity_error, bus.o_adapter_enable};
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Build a header word; cp is computed from bits [61:0], optionally inverted.
  function automatic logic [63:0] mk_hdr(input logic b56, input logic [7:0] mc,
                                         input logic [4:0] op, input logic dp,
                                         input logic good_cp);
    logic [63:0] d;
    d = '0;
    d[56]    = b56;
    d[21:14] = mc;
    d[4:0]   = op;
    d[63]    = dp;
    d[62]    = ($countones(d[61:0]) % 2 == 1) ^ ~good_cp;
    return d;
  endfunction

  // Drive one cycle of inputs at the falling edge, let a rising edge take it,
  // return at the next falling edge where outputs are sampled.
  task automatic step(input logic dn, input logic [63:0] d, input logic st,
                      input logic hv, input logic rv, input logic dv);
    bus.i_de_ser_done  = dn;
    bus.i_deser_data   = d;
    bus.i_state        = st;
    bus.i_header_valid = hv;
    bus.i_rdi_valid    = rv;
    bus.i_data_valid   = dv;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    step(0, '0, 0, 0, 0, 0);
    chk("reset_outputs", outs(), 10'b0);
    i_rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Tracks what the receiver is waiting for next, not how the RTL encodes it.
  typedef enum int {W_SYNC0, W_SYNC1, W_HDR, W_HDR_DONE, W_PAYLOAD, W_DATA_DONE, W_RDI_DONE} wait_t;
  wait_t       m_wait;
  logic [63:0] m_hdr;

  function automatic logic odd(input logic [63:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic model_step(input logic dn, input logic [63:0] d, input logic st,
                            input logic hv, input logic rv, input logic dv,
                            output logic [9:0] exp);
    logic start, samp, msg, rdi, rsp, perr, aen;
    logic [63:0] low62;
    start = 0; samp = 0; msg = 0; rdi = 0; rsp = 0; perr = 0; aen = 0;
    low62 = {2'b00, d[61:0]};
    case (m_wait)
      W_SYNC0: if (dn && d == PAT) begin m_wait = W_SYNC1; start = 1; end
      W_SYNC1: if (dn) begin
        if (d != PAT) m_wait = W_SYNC0;
        else if (st) begin m_wait = W_HDR; samp = 1; end
      end
      W_HDR: if (dn && d != PAT) begin
        if (d[62] != odd(low62))    perr = 1;
        else if (d[56] == 0)        aen = 1;
        else if (d[21:18] == 0)     m_wait = W_RDI_DONE;
        else begin m_hdr = d; m_wait = W_HDR_DONE; end
      end
      W_HDR_DONE: if (hv) begin
        if (m_hdr[4:0] == 5'd27) m_wait = W_PAYLOAD;
        else begin m_wait = W_HDR; msg = 1; rsp = (m_hdr[17:14] == 4'hA); end
      end
      W_PAYLOAD: if (dn) begin
        if (m_hdr[63] == odd(d)) m_wait = W_DATA_DONE;
        else begin m_wait = W_HDR; perr = 1; end
      end
      W_DATA_DONE: if (dv) begin m_wait = W_HDR; msg = 1; rsp = (m_hdr[17:14] == 4'hA); end
      W_RDI_DONE:  if (rv) begin m_wait = W_HDR; rdi = 1; end
      default: m_wait = W_SYNC0;
    endcase
    exp = {start, samp, m_wait == W_HDR_DONE, m_wait == W_RDI_DONE,
           m_wait == W_DATA_DONE, msg, rdi, rsp, perr, aen};
  endtask

  function automatic logic [63:0] rand_word();
    int r;
    logic [3:0] hi, lo;
    r = $urandom_range(0, 9);
    if (r < 3) return PAT;
    if (r < 8) begin
      hi = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      lo = ($urandom_range(0, 1) == 1) ? 4'hA : 4'($urandom);
      return mk_hdr($urandom_range(0, 7) != 0, {hi, lo},
                    ($urandom_range(0, 1) == 1) ? 5'd27 : 5'($urandom),
                    1'($urandom), $urandom_range(0, 7) != 0);
    end
    return {$urandom, $urandom};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic        dn;
    logic [63:0] d;
    logic        st, hv, rv, dv;
    logic [9:0]  exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input string n, input logic dn, input logic [63:0] d,
                             input logic st, input logic hv, input logic rv,
                             input logic dv, input logic [9:0] exp);
    vec_t x;
    x.name = n; x.dn = dn; x.d = d; x.st = st; x.hv = hv; x.rv = rv; x.dv = dv; x.exp = exp;
    return x;
  endfunction

  initial begin
    logic [63:0] h95, h9a, hrdi, h95bad;
    logic [9:0]  e;

    bus.i_de_ser_done = 0; bus.i_deser_data = '0; bus.i_state = 0;
    bus.i_header_valid = 0; bus.i_rdi_valid = 0; bus.i_data_valid = 0;

    h95    = mk_hdr(1, 8'h95, 5'd0,  1'b0, 1'b1);
    h9a    = mk_hdr(1, 8'h9A, 5'd27, 1'b1, 1'b1);
    hrdi   = mk_hdr(1, 8'h03, 5'd0,  1'b0, 1'b1);
    h95bad = mk_hdr(1, 8'h95, 5'd0,  1'b0, 1'b0);

    tbl.push_back(v("idle_ignores_word",  1, 64'h1234,  0,0,0,0, 10'b00_0000_0000));
    tbl.push_back(v("first_pattern",      1, PAT,       0,0,0,0, 10'b10_0000_0000));
    tbl.push_back(v("pattern_state0_hold",1, PAT,       0,0,0,0, 10'b00_0000_0000));
    tbl.push_back(v("no_strobe",          0, PAT,       1,0,0,0, 10'b00_0000_0000));
    tbl.push_back(v("second_pattern",     1, PAT,       1,0,0,0, 10'b01_0000_0000));
    tbl.push_back(v("gen_drops_pattern",  1, PAT,       1,0,0,0, 10'b00_0000_0000));
    tbl.push_back(v("hdr95_enable",       1, h95,       1,0,0,0, 10'b00_1000_0000));
    tbl.push_back(v("hdr95_hold",         0, h95,       1,0,0,0, 10'b00_1000_0000));
    tbl.push_back(v("hdr95_msg_req",      0, '0,        1,1,0,0, 10'b00_0001_0000));
    tbl.push_back(v("hdr9a_enable",       1, h9a,       1,0,0,0, 10'b00_1000_0000));
    tbl.push_back(v("hdr9a_to_dwait",     0, '0,        1,1,0,0, 10'b00_0000_0000));
    tbl.push_back(v("dwait_ignores_vld",  0, '0,        1,1,1,1, 10'b00_0000_0000));
    tbl.push_back(v("payload_dp_ok",      1, 64'h1,     1,0,0,0, 10'b00_0010_0000));
    tbl.push_back(v("data_msg_rsp",       0, '0,        1,0,0,1, 10'b00_0001_0100));
    tbl.push_back(v("rdi_enable",         1, hrdi,      1,0,0,0, 10'b00_0100_0000));
    tbl.push_back(v("rdi_msg",            0, '0,        1,0,1,0, 10'b00_0000_1000));
    tbl.push_back(v("adapter_zero_hdr",   1, 64'h0,     1,0,0,0, 10'b00_0000_0001));
    tbl.push_back(v("cp_inverted",        1, h95bad,    1,0,0,0, 10'b00_0000_0010));
    tbl.push_back(v("hdr9a_again",        1, h9a,       1,0,0,0, 10'b00_1000_0000));
    tbl.push_back(v("to_dwait_again",     0, '0,        1,1,0,0, 10'b00_0000_0000));
    tbl.push_back(v("payload_dp_bad",     1, 64'h3,     1,0,0,0, 10'b00_0000_0010));
    tbl.push_back(v("back_in_general",    1, h95,       1,0,0,0, 10'b00_1000_0000));

    @(negedge i_clk);
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].dn, tbl[i].d, tbl[i].st, tbl[i].hv, tbl[i].rv, tbl[i].dv);
      chk(tbl[i].name, outs(), tbl[i].exp);
    end

    // Non-pattern word while hunting for the second pattern restarts the hunt.
    do_reset();
    step(1, PAT, 0, 0, 0, 0);
    chk("restart_first", outs(), 10'b10_0000_0000);
    step(1, 64'h5555, 1, 0, 0, 0);
    chk("restart_abort", outs(), 10'b00_0000_0000);
    step(1, PAT, 1, 0, 0, 0);
    chk("restart_needs_two", outs(), 10'b10_0000_0000);

    // Asynchronous reset while in DATA_DECODE.
    step(1, PAT, 1, 0, 0, 0);
    step(1, h9a, 1, 0, 0, 0);
    step(0, '0, 1, 1, 0, 0);
    step(1, 64'h1, 1, 0, 0, 0);
    chk("dd_before_reset", outs(), 10'b00_0010_0000);
    #2 i_rst_n = 1'b0;
    #1 chk("async_reset_now", outs(), 10'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(1, PAT, 1, 0, 0, 0);
    chk("post_reset_first_only", outs(), 10'b10_0000_0000);
    step(0, '0, 1, 0, 0, 1);
    chk("post_reset_data_vld_ignored", outs(), 10'b00_0000_0000);

    // Randomized traffic against the model.
    do_reset();
    m_wait = W_SYNC0;
    m_hdr  = '0;
    for (int k = 0; k < 4000; k++) begin
      logic dn, st, hv, rv, dv;
      logic [63:0] d;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        m_wait = W_SYNC0;
        m_hdr  = '0;
      end
      dn = $urandom_range(0, 1);
      d  = rand_word();
      st = $urandom_range(0, 3) != 0;
      hv = $urandom_range(0, 3) == 0;
      rv = $urandom_range(0, 3) == 0;
      dv = $urandom_range(0, 3) == 0;
      step(dn, d, st, hv, rv, dv);
      model_step(dn, d, st, hv, rv, dv, e);
      chk("random", outs(), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
